// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux
// Four-digit multiplexed 7-segment driver. It scans one digit per edge of the
// divider output and decodes a frame-latched 16-bit hex value to active-low
// segment and anode drive. It blanks all anodes after each digit switch and can
// suppress leading zeros.
//
// Ports:
//   clk      system clock (same clock as the divider)
//   rst      asynchronous reset, active low
//   fdiv     divider square wave, asynchronous, synchronised internally
//   value    display value, digit 0 = value[3:0] (rightmost)
//   dp_en    decimal point enable per digit, active high
//   blank_lz leading-zero suppression enable (sampled live)
//   an       anode enables, active low, bit i = digit i
//   seg      segments {g,f,e,d,c,b,a}, active low
//   dp       decimal point, active low
module seg7_scan_mux #(
    parameter int unsigned BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fdiv,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [7:0] BlankInit = 8'(BLANK_CYC);

    logic        s1, s2, s3;
    logic        tick;
    logic [1:0]  idx;
    logic [15:0] frame;
    logic [3:0]  dp_l;
    logic [7:0]  cnt;

    logic [1:0]  idx_d;
    logic [15:0] frame_d;
    logic [3:0]  dp_l_d;
    logic [7:0]  cnt_d;
    logic [3:0]  an_d;
    logic [6:0]  seg_d;
    logic        dp_d;
    logic [3:0]  nz;
    logic        blanked;
    logic [3:0]  nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] r;
        unique case (n)
            4'h0: r = 7'b1000000;
            4'h1: r = 7'b1111001;
            4'h2: r = 7'b0100100;
            4'h3: r = 7'b0110000;
            4'h4: r = 7'b0011001;
            4'h5: r = 7'b0010010;
            4'h6: r = 7'b0000010;
            4'h7: r = 7'b1111000;
            4'h8: r = 7'b0000000;
            4'h9: r = 7'b0010000;
            4'hA: r = 7'b0001000;
            4'hB: r = 7'b0000011;
            4'hC: r = 7'b1000110;
            4'hD: r = 7'b0100001;
            4'hE: r = 7'b0000110;
            default: r = 7'b0001110;
        endcase
        return r;
    endfunction

    // Outputs are registered from the next-state values so that the new digit
    // and the anode blanking show up on the same edge as the index change.
    always_comb begin
        idx_d   = tick ? idx + 2'd1 : idx;
        frame_d = frame;
        dp_l_d  = dp_l;
        // Latch the frame on the 3->0 wrap only, so mid-frame edits never tear.
        if (tick && idx == 2'd3) begin
            frame_d = value;
            dp_l_d  = dp_en;
        end

        if (tick)            cnt_d = BlankInit;
        else if (cnt != '0)  cnt_d = cnt - 8'd1;
        else                 cnt_d = '0;

        for (int i = 0; i < 4; i++) nz[i] = |frame_d[i*4 +: 4];

        unique case (idx_d)
            2'd3:    blanked = blank_lz && !nz[3];
            2'd2:    blanked = blank_lz && !(nz[3] | nz[2]);
            2'd1:    blanked = blank_lz && !(nz[3] | nz[2] | nz[1]);
            default: blanked = 1'b0;
        endcase

        nib   = frame_d[{idx_d, 2'b00} +: 4];
        seg_d = blanked ? 7'b1111111 : hex7(nib);
        dp_d  = blanked ? 1'b1 : ~dp_l_d[idx_d];

        if (cnt_d != '0) begin
            an_d = 4'b1111;
        end else begin
            unique case (idx_d)
                2'd0:    an_d = 4'b1110;
                2'd1:    an_d = 4'b1101;
                2'd2:    an_d = 4'b1011;
                default: an_d = 4'b0111;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            tick  <= 1'b0;
            idx   <= 2'd0;
            frame <= '0;
            dp_l  <= '0;
            cnt   <= BlankInit;
            an    <= 4'b1111;
            seg   <= 7'b1111111;
            dp    <= 1'b1;
        end else begin
            s1    <= fdiv;
            s2    <= s1;
            s3    <= s2;
            // Registered edge detect: both fdiv edges produce a one-cycle tick.
            tick  <= s2 ^ s3;
            idx   <= idx_d;
            frame <= frame_d;
            dp_l  <= dp_l_d;
            cnt   <= cnt_d;
            an    <= an_d;
            seg   <= seg_d;
            dp    <= dp_d;
        end
    end

endmodule
